// File: rtl/proc_mem_pkg.sv
// Shared definitions for the writable program store and its loader.
package proc_mem_pkg;

    // Loader / fetch-blocking state machine encoding
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_W;

    // Opcode of the no-operation instruction, shared with the decoder
    localparam logic [3:0] NOP_OPCODE = 4'b0000;

    // Bytes needed to assemble one instruction word of the given width
    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-serial word assembler: shifts bytes in MSB-first and flags the
// accepted byte that completes a word.
module word_assembler
    import proc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic [7:0]            byte_i,
    input  logic                  accept_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_ready_o
);

    localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Next-state: a restart discards the partial word, otherwise shift in
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept_i) begin
            // Earlier bytes move toward the MSB; the first byte ends on top
            shift_d = DATA_WIDTH'({shift_q, byte_i});
            cnt_d   = (cnt_q == LAST_BYTE) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Shift register and byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = shift_q;
    assign word_ready_o = accept_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/program_memory.sv
// Writable program store: registered fetch port plus byte-serial loader
// that blocks fetch while a new program is streamed in.
module program_memory
    import proc_mem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter string                 INIT_FILE  = "",
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    input  logic                  load_start,
    input  logic [7:0]            load_byte,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  valid_q;

    logic                  accept;
    logic                  we;
    logic                  fetch_go;
    logic                  fetch_blk;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  word_ready;

    // Power-up image; reset deliberately leaves the array untouched
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    assign load_ready = (state_q == COLLECT);
    assign load_busy  = (state_q != RUN);
    assign accept     = load_valid && load_ready;

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (load_start),
        .byte_i       (load_byte),
        .accept_i     (accept),
        .word_o       (asm_word),
        .word_ready_o (word_ready)
    );

    // Next-state, write strobe and fetch gating; load_start wins everywhere
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        we        = 1'b0;
        fetch_go  = 1'b0;
        fetch_blk = 1'b1;
        if (load_start) begin
            state_d = COLLECT;
            ptr_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    fetch_blk = 1'b0;
                    fetch_go  = fetch_en;
                end
                COLLECT: begin
                    if (word_ready) state_d = WRITE;
                end
                WRITE: begin
                    we = 1'b1;
                    if (count_q != FULL_COUNT) count_d = count_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = RUN;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = COLLECT;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Control registers and registered fetch port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            valid_q <= fetch_go;
            if (fetch_go)       instr_q <= mem_q[fetch_addr];
            else if (fetch_blk) instr_q <= NOP_WORD;
        end
    end

    // Synchronous write port of the program RAM
    always_ff @(posedge clk) begin
        if (we) mem_q[ptr_q] <= asm_word;
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign load_done   = done_q;
    assign load_count  = count_q;

endmodule
